// File: rtl/truth_table_checker.sv
// truth_table_checker
// Response-side checker for small 3-input combinational circuits. Each
// accepted (A,B,C,Z) tuple is compared against the EXPECT truth table. The
// block tracks coverage of the 8 input combinations, counts mismatches with
// saturation, latches the first failing vector, and reports pass/fail once
// all 8 combinations have been seen. Every output comes straight from a flop.
`timescale 1ns/1ps

module truth_table_checker #(
  parameter logic [7:0] EXPECT = 8'hC8,
  parameter int         ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_c,
  input  logic             in_z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       cover_mask,
  output logic             first_fail_valid,
  output logic [2:0]       first_fail_vec
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

  // Case-inequality on purpose: an X or Z on the response counts as a mismatch
  // in simulation, while synthesis sees an ordinary inequality.
  function automatic logic mismatch_f(input logic z, input logic expected);
    return (z !== expected);
  endfunction

  logic [1:0]       state_r;
  logic             in_ready_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [ERR_W-1:0] err_r;
  logic [7:0]       cover_r;
  logic             ffv_r;
  logic [2:0]       ffvec_r;

  logic [1:0]       state_s;
  logic [ERR_W-1:0] err_s;
  logic [7:0]       cover_s;
  logic             ffv_s;
  logic [2:0]       ffvec_s;
  logic [2:0]       idx_s;
  logic [7:0]       hit_s;
  logic             accept_s;
  logic             mismatch_s;

  // Decode the incoming sample. A start in the same cycle discards the sample.
  always_comb begin
    idx_s      = {in_a, in_b, in_c};
    hit_s      = 8'h01 << idx_s;
    accept_s   = in_valid && in_ready_r && !start;
    mismatch_s = mismatch_f(in_z, EXPECT[idx_s]);
  end

  // Next-value logic for the run statistics: clear on start, else fold in the sample.
  always_comb begin
    err_s   = err_r;
    cover_s = cover_r;
    ffv_s   = ffv_r;
    ffvec_s = ffvec_r;
    if (start) begin
      err_s   = ERR_ZERO;
      cover_s = 8'h00;
      ffv_s   = 1'b0;
      ffvec_s = 3'b000;
    end else if (accept_s) begin
      cover_s = cover_r | hit_s;
      if (mismatch_s) begin
        if (err_r != ERR_MAX) begin
          err_s = err_r + ERR_ONE;
        end else begin
          err_s = err_r;
        end
        if (!ffv_r) begin
          ffv_s   = 1'b1;
          ffvec_s = idx_s;
        end else begin
          ffv_s   = ffv_r;
          ffvec_s = ffvec_r;
        end
      end else begin
        err_s = err_r;
      end
    end else begin
      cover_s = cover_r;
    end
  end

  // Run-control state machine; completion looks at coverage including this sample.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_CHECK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (start) begin
          state_s = ST_CHECK;
        end else if (accept_s && (cover_s == 8'hFF)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_CHECK;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_s = ST_CHECK;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, statistics and status flags; status flags are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      err_r      <= ERR_ZERO;
      cover_r    <= 8'h00;
      ffv_r      <= 1'b0;
      ffvec_r    <= 3'b000;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == ST_CHECK);
      busy_r     <= (state_s == ST_CHECK);
      done_r     <= (state_s == ST_DONE);
      pass_r     <= (state_s == ST_DONE) && (err_s == ERR_ZERO);
      err_r      <= err_s;
      cover_r    <= cover_s;
      ffv_r      <= ffv_s;
      ffvec_r    <= ffvec_s;
    end
  end

  assign in_ready         = in_ready_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign err_count        = err_r;
  assign cover_mask       = cover_r;
  assign first_fail_valid = ffv_r;
  assign first_fail_vec   = ffvec_r;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: directed vectors, a scoreboard queue of
// expected post-sample snapshots, and a monitor that pops on each accepted
// sample. A second instance with ERR_W=2 shares the stimulus to exercise
// counter saturation.
`timescale 1ns/1ps

module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_a = 1'b0;
  logic       in_b = 1'b0;
  logic       in_c = 1'b0;
  logic       in_z = 1'b0;

  logic       in_ready, busy, done, pass, first_fail_valid;
  logic [7:0] err_count, cover_mask;
  logic [2:0] first_fail_vec;

  logic       in_ready2, busy2, done2, pass2, ffv2;
  logic [1:0] err_count2;
  logic [7:0] cover_mask2;
  logic [2:0] ffvec2;

  truth_table_checker #(.EXPECT(8'hC8), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_z(in_z),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .cover_mask(cover_mask), .first_fail_valid(first_fail_valid),
    .first_fail_vec(first_fail_vec)
  );

  truth_table_checker #(.EXPECT(8'hC8), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready2), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_z(in_z),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .cover_mask(cover_mask2), .first_fail_valid(ffv2),
    .first_fail_vec(ffvec2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] cov;
    logic [7:0] err;
    logic       ffv;
    logic [2:0] ffvec;
    logic       dn;
    logic       ps;
    logic       bsy;
  } snap_t;

  snap_t      exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  logic [7:0] m_cov = 8'h00;
  logic [7:0] m_err = 8'h00;
  logic       m_ffv = 1'b0;
  logic [2:0] m_ffvec = 3'b000;

  // Z = A.B + B.C written out independently of the DUT's table parameter.
  function automatic logic golden_z(input logic [2:0] v);
    return (v[2] & v[1]) | (v[1] & v[0]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cov = 8'h00; m_err = 8'h00; m_ffv = 1'b0; m_ffvec = 3'b000;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
  endtask

  // Present one sample, push the expected post-sample snapshot, then idle gap cycles.
  task automatic send(input logic [2:0] v, input logic z, input int gap);
    snap_t e;
    in_a = v[2]; in_b = v[1]; in_c = v[0]; in_z = z; in_valid = 1'b1;
    m_cov = m_cov | (8'h01 << v);
    if (z != golden_z(v)) begin
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      if (!m_ffv) begin
        m_ffv = 1'b1;
        m_ffvec = v;
      end
    end
    e.cov = m_cov; e.err = m_err; e.ffv = m_ffv; e.ffvec = m_ffvec;
    e.dn = (m_cov == 8'hFF);
    e.ps = (m_cov == 8'hFF) && (m_err == 8'h00);
    e.bsy = (m_cov != 8'hFF);
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
    chk({tag, "_cover"}, 32'(cover_mask), 32'd0);
    chk({tag, "_ffv"}, 32'(first_fail_valid), 32'd0);
    chk({tag, "_ffvec"}, 32'(first_fail_vec), 32'd0);
  endtask

  // Monitor: note each accepted handshake on the rising edge, compare on the falling edge.
  initial begin
    logic  acc;
    snap_t act;
    snap_t e;
    forever begin
      @(posedge clk);
      acc = in_valid && in_ready && !start && rst_n;
      @(negedge clk);
      if (acc) begin
        act = {cover_mask, err_count, first_fail_valid, first_fail_vec, done, pass, busy};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_accept: got snapshot %0h with no expected entry (t=%0t)", act, $time);
        end else begin
          e = exp_q.pop_front();
          chk("scoreboard", 32'(act), 32'(e));
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // Golden exhaustive run
    do_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_in_ready", 32'(in_ready), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    for (int v = 0; v < 8; v++) begin
      if (v == 7) chk("golden_not_done_before_last", 32'(done), 32'd0);
      send(3'(v), golden_z(3'(v)), 0);
    end
    chk("golden_done", 32'(done), 32'd1);
    chk("golden_pass", 32'(pass), 32'd1);
    chk("golden_err", 32'(err_count), 32'd0);
    chk("golden_cover", 32'(cover_mask), 32'hFF);
    chk("golden_ffv", 32'(first_fail_valid), 32'd0);
    chk("golden_busy", 32'(busy), 32'd0);
    // Samples offered in DONE must be ignored (monitor flags any acceptance)
    in_a = 1'b0; in_b = 1'b0; in_c = 1'b0; in_z = 1'b1; in_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("done_hold", 32'(done), 32'd1);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("done_err_unchanged", 32'(err_count), 32'd0);

    // Single fault on vector 110
    do_start();
    for (int v = 0; v < 8; v++) begin
      send(3'(v), (v == 6) ? 1'b0 : golden_z(3'(v)), 0);
    end
    chk("single_done", 32'(done), 32'd1);
    chk("single_pass", 32'(pass), 32'd0);
    chk("single_err", 32'(err_count), 32'd1);
    chk("single_ffvec", 32'(first_fail_vec), 32'd6);
    chk("single_ffv", 32'(first_fail_valid), 32'd1);

    // Out of order with duplicates and gaps
    do_start();
    send(3'd7, 1'b1, 1);
    send(3'd0, 1'b0, 2);
    send(3'd7, 1'b1, 1);
    chk("ooo_dup_not_done", 32'(done), 32'd0);
    chk("ooo_dup_cover", 32'(cover_mask), 32'h81);
    send(3'd3, 1'b1, 0);
    send(3'd1, 1'b0, 1);
    send(3'd2, 1'b0, 0);
    send(3'd4, 1'b0, 2);
    send(3'd5, 1'b0, 0);
    chk("ooo_not_done_before_6", 32'(done), 32'd0);
    send(3'd6, 1'b1, 0);
    chk("ooo_done", 32'(done), 32'd1);
    chk("ooo_pass", 32'(pass), 32'd1);
    chk("ooo_err", 32'(err_count), 32'd0);

    // Multiple faults on 011 then 101, then start clears everything
    do_start();
    for (int v = 0; v < 8; v++) begin
      send(3'(v), (v == 3 || v == 5) ? ~golden_z(3'(v)) : golden_z(3'(v)), 0);
    end
    chk("multi_err", 32'(err_count), 32'd2);
    chk("multi_ffvec", 32'(first_fail_vec), 32'd3);
    chk("multi_pass", 32'(pass), 32'd0);
    do_start();
    chk("clear_err", 32'(err_count), 32'd0);
    chk("clear_cover", 32'(cover_mask), 32'd0);
    chk("clear_ffv", 32'(first_fail_valid), 32'd0);
    chk("clear_ffvec", 32'(first_fail_vec), 32'd0);
    chk("clear_busy", 32'(busy), 32'd1);
    chk("clear_done", 32'(done), 32'd0);

    // Restart mid-run: the sample presented with start is discarded
    send(3'd1, 1'b1, 0);
    send(3'd2, 1'b0, 0);
    in_a = 1'b1; in_b = 1'b1; in_c = 1'b1; in_z = 1'b0; in_valid = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    model_clear();
    chk("restart_cover", 32'(cover_mask), 32'd0);
    chk("restart_err", 32'(err_count), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);

    // Saturation: 5 wrong samples of 000, then remaining vectors correctly
    for (int k = 0; k < 5; k++) begin
      send(3'd0, 1'b1, 0);
      if (k == 2) chk("sat2_err_at3", 32'(err_count2), 32'd3);
    end
    for (int v = 1; v < 8; v++) begin
      send(3'(v), golden_z(3'(v)), 0);
    end
    chk("sat_main_err", 32'(err_count), 32'd5);
    chk("sat2_err", 32'(err_count2), 32'd3);
    chk("sat2_pass", 32'(pass2), 32'd0);
    chk("sat2_done", 32'(done2), 32'd1);
    chk("sat2_ffvec", 32'(ffvec2), 32'd0);

    // Reset mid-run, then in_valid without start must be ignored
    do_start();
    for (int v = 0; v < 4; v++) begin
      send(3'(v), golden_z(3'(v)), 0);
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_a = 1'b1; in_b = 1'b0; in_c = 1'b1; in_z = 1'b1; in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("idle_ignore_in_ready", 32'(in_ready), 32'd0);
    chk("idle_ignore_cover", 32'(cover_mask), 32'd0);
    chk("idle_ignore_err", 32'(err_count), 32'd0);
    chk("idle_ignore_busy", 32'(busy), 32'd0);

    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Response-side companion to the team's small combinational gate circuits.
- The stimulus side drives input vectors {A,B,C} into a circuit under test. This block consumes the resulting (A,B,C,Z) tuples and checks each Z against a parameterised 3-input truth table.
- It tracks which of the 8 input combinations have been seen, counts mismatches, and latches the first failing vector.
- It reports pass or fail once all 8 combinations have been covered. Usable as an on-chip self-check or as a bench monitor.

Parameters:
- EXPECT, 8'hC8, expected Z per vector index {A,B,C}; bit i is the Z expected for index i. The default encodes Z = A·B + B·C.
- ERR_W, 8, width of the mismatch counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request that clears statistics and begins a check run.
- in_valid  input  1  sample tuple is present this cycle.
- in_ready  output  1  block accepts a sample this cycle.
- in_a  input  1  sampled A.
- in_b  input  1  sampled B.
- in_c  input  1  sampled C.
- in_z  input  1  circuit response to be checked.
- busy  output  1  run in progress (state CHECK).
- done  output  1  all 8 vectors covered; holds until the next start.
- pass  output  1  meaningful only when done=1; 1 iff err_count==0.
- err_count  output  ERR_W  number of mismatches in this run; saturates at all-ones.
- cover_mask  output  8  bit i set once vector index i has been accepted.
- first_fail_valid  output  1  at least one mismatch has been captured.
- first_fail_vec  output  3  {A,B,C} of the first mismatching sample.

Behaviour:
- Reset (asynchronous, rst_n=0) puts the block in IDLE. All outputs are 0: in_ready, busy, done, pass, err_count, cover_mask, first_fail_valid, first_fail_vec.
- States:
  - IDLE: in_ready=0. start → CHECK.
  - CHECK: in_ready=1, busy=1.
  - DONE: in_ready=0, done=1. start → CHECK.
- start clears err_count, cover_mask, first_fail_valid and first_fail_vec on the same edge that enters CHECK. A start asserted while in CHECK restarts the run with the same clearing; any sample arriving in that cycle is discarded.
- Accept: a sample is accepted when in_valid && in_ready, on that rising edge.
  - idx = {in_a,in_b,in_c}.
  - mismatch = (in_z !== EXPECT[idx]); X or Z on in_z counts as a mismatch.
- Per accepted sample:
  - cover_mask[idx] <= 1.
  - If mismatch: err_count increments, saturating.
  - If mismatch and first_fail_valid==0: first_fail_vec <= idx and first_fail_valid <= 1.
- Duplicate vectors are legal. They are checked and counted again, and cover_mask is unchanged by them.
- Completion: if cover_mask, including the current accepted sample, equals 8'hFF, the state goes to DONE on that same edge.
  - done and pass are visible from the cycle after the 8th distinct vector.
  - The result already includes that final sample.
- Latency: one cycle from acceptance to updated err_count, cover_mask and first_fail outputs.
- in_valid is ignored when in_ready=0. Nothing is buffered and there is no backpressure beyond in_ready.
- pass = done && (err_count == 0), registered.
- Saturation: err_count stays at 2^ERR_W−1 once reached. pass remains 0.
- Reset mid-run aborts immediately and returns to the reset values. No partial result is retained.

Test Plan:
- Golden exhaustive: start, then 8 samples 000..111 with Z from A·B+B·C, one per cycle → done=1 the cycle after the 8th sample; pass=1, err_count=0, cover_mask=8'hFF, first_fail_valid=0.
- Single fault: same sequence with Z=0 for vector 110 → done=1, pass=0, err_count=1, first_fail_vec=3'b110, first_fail_valid=1.
- Out-of-order with duplicates: vectors 7,0,7,3,1,2,4,5,6, all correct, with in_valid gaps → done only after 6 is accepted; err_count=0; done stays 0 through the duplicate 7.
- Multiple faults: wrong Z on 011 then 101 → err_count=2, first_fail_vec=3'b011. Then start → all stats cleared, busy=1, done=0.
- Saturation: ERR_W=2, feed 5 wrong samples of vector 000 then the 7 remaining vectors correctly → err_count=2'b11, pass=0.
- Reset/ignore: drop rst_n mid-run after 4 samples → all outputs 0 and state IDLE. Then in_valid with start=0 → in_ready=0, no stats change.
